// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (FSM state encoding, parity modes) for TX and RX.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Tick counter must hold 0..15 for data bits and 0..SB_TICK-1 in STOP.
    function automatic int tick_cnt_width(input int sb_tick);
        return ($clog2(sb_tick) > 4) ? $clog2(sb_tick) : 4;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Purpose: bundle of the UART transmitter request/line/status signals.
// Latency: n/a (wiring only).
// Backpressure: master must watch tx_busy; requests while busy are dropped.
interface uart_tx_if;

    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;

    modport master (
        output s_tick, tx_start, din,
        input  tx, tx_busy, tx_done_tick
    );

    modport slave (
        input  s_tick, tx_start, din,
        output tx, tx_busy, tx_done_tick
    );

endinterface

// File: rtl/uart_tx.sv
// Purpose: UART serialiser: start, DBIT data bits LSB first, optional parity, stop.
// Latency: tx goes low 1 clk after acceptance; each bit lasts 16 s_ticks, stop SB_TICK.
// Backpressure: none; tx_start outside IDLE is ignored, caller must wait for tx_busy low.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam int             SW         = tick_cnt_width(SB_TICK);
    localparam logic [SW-1:0]  S_BIT_LAST = SW'(15);
    localparam logic [SW-1:0]  S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]     N_LAST     = 3'(DBIT - 1);

    uart_state_t   state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic          p_q, p_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;

    // State and datapath registers; reset parks the line idle-high and drops any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; tx_d reflects the current state so the line lags state by one clk.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_start) begin
                    state_d = ST_START;
                    b_d     = bus.din;
                    s_d     = '0;
                    n_d     = '0;
                    p_d     = (PARITY == PAR_ODD);
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bus.s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                tx_d = b_q[0];
                if (bus.s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = {1'b0, b_q[7:1]};
                        p_d = p_q ^ b_q[0];
                        if (n_q == N_LAST) begin
                            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_PARITY: begin
                tx_d = p_q;
                if (bus.s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bus.s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign bus.tx           = tx_q;
    assign bus.tx_busy      = (state_q != ST_IDLE);
    assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Purpose: self-checking bench for uart_tx across parity modes and stop lengths.
// Latency: line level is compared once per s_tick against a frame-level model.
// Backpressure: stimulus respects the no-queuing rule except where it deliberately pokes.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    int         sel;
    int         ticks;
    int         tests;
    int         fails;
    int         done_q[$];
    logic [7:0] fb[3];

    logic tx_w[4];
    logic busy_w[4];
    logic done_w[4];

    uart_tx_if if0 ();
    uart_tx_if if1 ();
    uart_tx_if if2 ();
    uart_tx_if if3 ();

    assign if0.s_tick = s_tick;  assign if0.din = din;  assign if0.tx_start = tx_start && (sel == 0);
    assign if1.s_tick = s_tick;  assign if1.din = din;  assign if1.tx_start = tx_start && (sel == 1);
    assign if2.s_tick = s_tick;  assign if2.din = din;  assign if2.tx_start = tx_start && (sel == 2);
    assign if3.s_tick = s_tick;  assign if3.din = din;  assign if3.tx_start = tx_start && (sel == 3);

    assign tx_w[0] = if0.tx;  assign busy_w[0] = if0.tx_busy;  assign done_w[0] = if0.tx_done_tick;
    assign tx_w[1] = if1.tx;  assign busy_w[1] = if1.tx_busy;  assign done_w[1] = if1.tx_done_tick;
    assign tx_w[2] = if2.tx;  assign busy_w[2] = if2.tx_busy;  assign done_w[2] = if2.tx_done_tick;
    assign tx_w[3] = if3.tx;  assign busy_w[3] = if3.tx_busy;  assign done_w[3] = if3.tx_done_tick;

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    uart_tx #(.DBIT(7), .SB_TICK(24), .PARITY(2)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the tick count at every cycle the selected transmitter reports completion.
    always @(negedge clk) begin
        if (done_w[sel] === 1'b1) done_q.push_back(ticks);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int dbit_of(input int k);
        return (k == 3) ? 7 : 8;
    endfunction

    function automatic int par_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 2);
    endfunction

    function automatic int sb_of(input int k);
        return (k == 3) ? 24 : 16;
    endfunction

    function automatic int frame_len(input int k);
        return 16 * (1 + dbit_of(k) + ((par_of(k) != 0) ? 1 : 0)) + sb_of(k);
    endfunction

    // Expected line level during tick t of a frame carrying byte d.
    function automatic logic exp_level(input int k, input logic [7:0] d, input int t);
        int   bit_i;
        logic par;
        bit_i = t / 16;
        if (bit_i == 0) return 1'b0;
        if (bit_i <= dbit_of(k)) return d[bit_i-1];
        if (par_of(k) != 0 && bit_i == dbit_of(k) + 1) begin
            par = (par_of(k) == 2);
            for (int i = 0; i < dbit_of(k); i++) par ^= d[i];
            return par;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Send nfr frames from fb[] back-to-back on DUT k, checking the line every tick.
    task automatic run_frames(input int k, input int nfr, input int poke_at,
                              input int freeze_at, input int abort_at);
        int len;
        int t_total;
        int fr;
        len     = frame_len(k);
        t_total = len * nfr;
        done_q.delete();
        ticks    = 0;
        sel      = k;
        din      = fb[0];
        tx_start = 1'b1;
        @(posedge clk); #1;
        if (nfr > 1) din = fb[1];
        else begin
            tx_start = 1'b0;
            din      = 8'($urandom);
        end
        for (int t = 0; t < t_total; t++) begin
            repeat ($urandom_range(2, 4)) @(posedge clk);
            #1;
            fr = t / len;
            chk("tx_level", tx_w[k], exp_level(k, fb[fr], t % len));
            chk("busy_in_frame", busy_w[k], 1'b1);
            if (t == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("abort_tx", tx_w[k], 1'b1);
                chk("abort_busy", busy_w[k], 1'b0);
                repeat (40) begin
                    s_tick = 1'b1; @(posedge clk); #1;
                    s_tick = 1'b0; @(posedge clk); #1;
                end
                chk("abort_no_done", done_q.size(), 0);
                chk("abort_idle_tx", tx_w[k], 1'b1);
                return;
            end
            if (t == freeze_at) begin
                repeat (1000) @(posedge clk);
                #1;
                chk("freeze_tx", tx_w[k], exp_level(k, fb[fr], t % len));
                chk("freeze_busy", busy_w[k], 1'b1);
                chk("freeze_no_done", done_q.size(), 0);
            end
            s_tick = 1'b1;
            @(posedge clk);
            ticks++;
            #1;
            s_tick = 1'b0;
            if (t == poke_at) begin
                tx_start = 1'b1;
                din      = 8'($urandom);
                @(posedge clk); #1;
                tx_start = 1'b0;
            end
            if ((t + 1) % len == 0 && (t + 1) < t_total) begin
                @(posedge clk); #1;
                fr = (t + 1) / len + 1;
                if (fr < nfr) din = fb[fr];
                else begin
                    tx_start = 1'b0;
                    din      = 8'($urandom);
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_q.size(), nfr);
        for (int i = 0; i < nfr && i < done_q.size(); i++)
            chk("done_at_tick", done_q[i], len * (i + 1));
        chk("end_tx", tx_w[k], 1'b1);
        chk("end_busy", busy_w[k], 1'b0);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        ticks    = 0;
        sel      = 0;
        rst      = 1'b1;
        s_tick   = 1'b0;
        tx_start = 1'b0;
        din      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_tx", tx_w[k], 1'b1);
            chk("rst_busy", busy_w[k], 1'b0);
            chk("rst_done", done_w[k], 1'b0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Reference frame 0xA5, no parity: 160 ticks.
        fb[0] = 8'hA5;
        run_frames(0, 1, -1, -1, -1);

        // Parity on 0x07: even -> 1, odd -> 0, 176 ticks.
        fb[0] = 8'h07;
        run_frames(1, 1, -1, -1, -1);
        run_frames(2, 1, -1, -1, -1);

        // tx_start held across three frames.
        fb[0] = 8'h55; fb[1] = 8'h00; fb[2] = 8'hFF;
        run_frames(0, 3, -1, -1, -1);

        // Request mid-frame must be ignored.
        fb[0] = 8'($urandom);
        run_frames(0, 1, 40, -1, -1);

        // Reset during data bit 3, then a clean frame.
        fb[0] = 8'($urandom);
        run_frames(0, 1, -1, -1, 70);
        fb[0] = 8'($urandom);
        run_frames(0, 1, -1, -1, -1);

        // s_tick stall in the middle of a bit.
        fb[0] = 8'($urandom);
        run_frames(0, 1, -1, 50, -1);

        // Random frames over all configurations, including 7 bits with 1.5 stop bits.
        for (int r = 0; r < 6; r++) begin
            fb[0] = 8'($urandom); fb[1] = 8'($urandom); fb[2] = 8'($urandom);
            run_frames(r % 4, $urandom_range(1, 2), -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8, meaning data bits per frame (5..8).
REQ-002 Parameter SB_TICK, default 16, meaning stop-bit length in s_tick units (16 = 1 stop bit, 24 = 1.5 stop bits, 32 = 2 stop bits).
REQ-003 Parameter PARITY, default 0, meaning parity mode (0 none, 1 even, 2 odd).
REQ-004 clk  input  1  meaning system clock (50 MHz); all logic on its rising edge.
REQ-005 rst  input  1  meaning synchronous, active-high reset.
REQ-006 s_tick  input  1  meaning 16x-baud enable pulse, one clk wide, from the TX-side baud tick generator.
REQ-007 tx_start  input  1  meaning transmit request, sampled every clk.
REQ-008 din  input  8  meaning byte to send; bits above DBIT-1 ignored.
REQ-009 tx  output  1  meaning serial line, registered, idle high.
REQ-010 tx_busy  output  1  meaning high in any state other than IDLE.
REQ-011 tx_done_tick  output  1  meaning one-clk pulse at frame completion.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP; registered state, tick counter s (4 bits, 0..15, widened to cover SB_TICK-1 in STOP), bit counter n (3 bits), shift register b (8 bits), parity accumulator p.
REQ-013 IDLE: tx=1; on tx_start=1 latch din into b, clear s and n, load p with 0 (even) or 1 (odd), go to START next clk.
REQ-014 tx_start while not in IDLE shall be ignored; no queuing; din may change freely after acceptance.
REQ-015 START: tx=0; s increments on each s_tick; on s_tick with s=15, clear s and go to DATA.
REQ-016 DATA: tx=b[0] (LSB first); on s_tick with s=15, shift b right, p ^= b[0], clear s; if n=DBIT-1, go to PARITY when PARITY!=0, else to STOP; otherwise n increments.
REQ-017 PARITY: tx=p; on s_tick with s=15, clear s and go to STOP.
REQ-018 STOP: tx=1; on s_tick with s=SB_TICK-1, go to IDLE and pulse tx_done_tick.
REQ-019 tx_done_tick high for exactly one clk, the cycle after the final stop s_tick; tx_start in that same cycle is accepted (back-to-back frames, no idle gap beyond one clk).
REQ-020 s_tick absent: state, counters and tx shall hold indefinitely.
REQ-021 Frame length = 16*(1+DBIT+(PARITY!=0)) + SB_TICK s_ticks.
REQ-022 tx shall come from a flop (no combinational glitches); tx changes one clk after the s_tick that ends a bit period.

Reset
REQ-023 rst=1 at any clk edge forces state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, s=0, n=0, b=0, p=0, taking priority over all inputs.
REQ-024 Reset mid-frame aborts the frame with no tx_done_tick; line returns high the next clk.

Structure
REQ-025 State encodings and parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) shall live in the shared package uart_pkg, used by TX and RX.
REQ-026 No sub-module; s_tick comes from an external baud generator instance selected by baud_sel.

Verification
REQ-027 DBIT=8, PARITY=0, SB_TICK=16, din=8'hA5, tx_start pulse -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 s_ticks; tx_done_tick once after 160 s_ticks.
REQ-028 PARITY=1, din=8'h07 -> parity bit 1; PARITY=2, same din -> parity bit 0; frame 176 s_ticks.
REQ-029 tx_start asserted every clk for 3 frames with din=8'h55,8'h00,8'hFF -> exactly 3 frames, start bit within 1 clk of each tx_done_tick, no dropped/extra frames.
REQ-030 tx_start pulse at s_tick 40 of an active frame -> ignored; frame content and length unchanged.
REQ-031 rst pulse during DATA bit 3 -> tx=1 next clk, tx_busy=0, no tx_done_tick; subsequent tx_start sends a full correct frame.
REQ-032 s_tick held low 1000 clks mid-bit -> tx and tx_busy frozen; resume completes the frame with correct bit widths.
